// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO: configurable data width, parity and stop bits.
// Frames leave back-to-back while the FIFO holds characters.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               i_Rst,
    input  logic                               i_DV,
    input  logic [DATA_BITS-1:0]               i_Byte,
    output logic                               o_Ready,
    output logic                               o_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_Fifo_Count,
    output logic                               o_Sig_Active,
    output logic                               o_Serial_Data,
    output logic                               o_Sig_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);
    localparam logic [NW-1:0] EMPTY     = NW'(0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~(^d);
        end else begin
            return ^d;
        end
    endfunction

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [NW-1:0]        r_count;
    logic                 r_ready, r_overflow;

    state_t               r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_serial, r_active, r_done;

    state_t               w_state_nxt;
    logic [CW-1:0]        w_clk_nxt;
    logic [BW-1:0]        w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_par_nxt, w_serial_nxt, w_done_nxt;
    logic                 w_push, w_pop, w_bit_end;
    logic [NW-1:0]        w_count_nxt;
    logic [DATA_BITS-1:0] w_head;

    // Push acceptance uses the registered full flag, independent of a same-edge pop.
    assign w_push    = i_DV & r_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_clk_cnt == LAST_CLK);

    // Next FIFO occupancy from this edge's push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + NW'(1);
            2'b01:   w_count_nxt = r_count - NW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents are discarded on reset through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Byte;
        end
    end

    // FIFO pointers, occupancy and host-side flags.
    always_ff @(posedge clk) begin
        if (i_Rst) begin
            r_wr_ptr   <= PW'(0);
            r_rd_ptr   <= PW'(0);
            r_count    <= EMPTY;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count    <= w_count_nxt;
            r_ready    <= (w_count_nxt != FULL);
            r_overflow <= i_DV & ~r_ready;
        end
    end

    // Frame sequencing: next state, counters, shift register and line value.
    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_serial_nxt = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_count != EMPTY) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_par_nxt   = parity_of(w_head);
                    w_clk_nxt   = CW'(0);
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_nxt   = CW'(0);
                    w_bit_nxt   = BW'(0);
                    w_state_nxt = S_DATA;
                end else begin
                    w_clk_nxt = r_clk_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_nxt = CW'(0);
                    if (r_bit_idx == LAST_DATA) begin
                        w_bit_nxt   = BW'(0);
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit_idx + BW'(1);
                        w_shift_nxt = r_shift >> 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_clk_nxt   = CW'(0);
                    w_bit_nxt   = BW'(0);
                    w_state_nxt = S_STOP;
                end else begin
                    w_clk_nxt = r_clk_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end && (r_bit_idx == LAST_STOP)) begin
                    w_clk_nxt  = CW'(0);
                    w_bit_nxt  = BW'(0);
                    w_done_nxt = 1'b1;
                    // Chain straight into the next frame when data is waiting.
                    if (r_count != EMPTY) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_par_nxt   = parity_of(w_head);
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_bit_end) begin
                    w_clk_nxt = CW'(0);
                    w_bit_nxt = r_bit_idx + BW'(1);
                end else begin
                    w_clk_nxt = r_clk_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clk_nxt   = CW'(0);
                w_bit_nxt   = BW'(0);
            end
        endcase

        case (w_state_nxt)
            S_START:  w_serial_nxt = 1'b0;
            S_DATA:   w_serial_nxt = w_shift_nxt[0];
            S_PARITY: w_serial_nxt = w_par_nxt;
            default:  w_serial_nxt = 1'b1;
        endcase
    end

    // Transmitter state and registered line outputs.
    always_ff @(posedge clk) begin
        if (i_Rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= CW'(0);
            r_bit_idx <= BW'(0);
            r_shift   <= {DATA_BITS{1'b0}};
            r_par     <= 1'b0;
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_serial  <= w_serial_nxt;
            r_active  <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign o_Ready       = r_ready;
    assign o_Overflow    = r_overflow;
    assign o_Fifo_Count  = r_count;
    assign o_Sig_Active  = r_active;
    assign o_Serial_Data = r_serial;
    assign o_Sig_Done    = r_done;

endmodule
